bus_serializer: RTL

Parallel-to-serial front end for the word multiplexer. Accepts a full SIZE-word frame in one handshake, holds it in a frame register, and sweeps the multiplexer select from word 0 to word SIZE-1, emitting one WIDTH-bit word per accepted output beat. It sits directly upstream of the multiplexer and owns its select counter; downstream consumers see a plain valid/ready word stream.

---
 rtl/serializer_pkg.sv | 14 +
 rtl/bus_serializer_mux.sv | 23 ++
 rtl/bus_serializer.sv | 95 +++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the bus serializer: FSM state encoding and index sizing.
package serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Width of the word index / multiplexer select for a frame of 'size' words.
  function automatic int unsigned idx_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/bus_serializer_mux.sv
// Word multiplexer: selects word iSelect out of a packed SIZE-word bus.
module Mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 128
) (
  input  logic [$clog2(SIZE)-1:0] iSelect,
  input  logic [SIZE*WIDTH-1:0]   iData,
  output logic [WIDTH-1:0]        oData
);

  localparam int unsigned SEL_W = $clog2(SIZE);

  // One-hot compare per word; out-of-range selects yield zero.
  always_comb begin
    oData = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (iSelect == SEL_W'(k)) begin
        oData = iData[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/bus_serializer.sv
// Parallel-to-serial front end: latches a SIZE-word frame, then sweeps the
// multiplexer select from word 0 to SIZE-1, one word per accepted beat.
module bus_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 128
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [SIZE*WIDTH-1:0]   iData,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [WIDTH-1:0]        oData,
  output logic [$clog2(SIZE)-1:0] oIndex,
  output logic                    oLast
);

  localparam int unsigned IDX_W = idx_width(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [SIZE*WIDTH-1:0]   frame_q;
  logic                    load_c;
  logic                    last_c;

  assign last_c = (index_q == LAST_IDX);

  // Next-state logic: load on IDLE handshake, advance or wrap on accepted beats.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          load_c  = 1'b1;
          index_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (iReady) begin
          if (last_c) begin
            index_d = '0;
            state_d = ST_IDLE;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        index_d = '0;
      end
    endcase
  end

  // State and index registers; reset wins over any handshake.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Frame register, written only on an IDLE handshake; contents survive reset.
  always_ff @(posedge iClock) begin
    if (!iReset && load_c) begin
      frame_q <= iData;
    end
  end

  Mux #(
    .WIDTH(WIDTH),
    .SIZE (SIZE)
  ) u_mux (
    .iSelect(index_q),
    .iData  (frame_q),
    .oData  (oData)
  );

  // Handshake flags follow the state register and are forced low during reset.
  assign oReady = ~iReset & (state_q == ST_IDLE);
  assign oValid = ~iReset & (state_q == ST_SEND);
  assign oIndex = index_q;
  assign oLast  = (state_q == ST_SEND) & last_c;

endmodule
